memref_multiport: RTL and testbench
===================================

MEMREF_MULTIPORT -- requirements
Module: memref_multiport

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter SIZE, default 8, number of words (any value >= 2, not necessarily a power of two).
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..8).
REQ-004 SHALL have parameter NUM_WR, default 1, number of independent write ports (1..4).
REQ-005 SHALL have parameter RD_LATENCY, default 1, cycles from rd_en sample to dout_valid (1..4).
REQ-006 SHALL have parameter RDW_MODE, default READ_OLD, read-during-write policy (READ_OLD or WRITE_FIRST).
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-009 SHALL have port rd_en, input, NUM_RD, per-port read request.
REQ-010 SHALL have port rd_addr, input, NUM_RD*AW, packed read addresses, port i at bits [i*AW +: AW], where AW = $clog2(SIZE).
REQ-011 SHALL have port dout_valid, output, NUM_RD, per-port read data valid.
REQ-012 SHALL have port dout, output, NUM_RD*WIDTH, packed read data, port i at bits [i*WIDTH +: WIDTH].
REQ-013 SHALL have port wr_en, input, NUM_WR, per-port write request.
REQ-014 SHALL have port wr_addr, input, NUM_WR*AW, packed write addresses.
REQ-015 SHALL have port din, input, NUM_WR*WIDTH, packed write data.
REQ-016 SHALL have port err_wr_conflict, output, 1, sticky flag: two or more write ports addressed the same word in one cycle.
REQ-017 SHALL have port err_oob, output, 1, sticky flag: an enabled access used an address >= SIZE.
REQ-018 SHALL have port err_count, output, 16, saturating count of cycles in which any error condition occurred.

Function
REQ-019 SHALL hold storage in an internal SIZE x WIDTH array; it SHALL NOT expose the array by reference.
REQ-020 SHALL commit each write (wr_en[j], in-range address) on the clk edge where wr_en[j] is sampled high.
REQ-021 SHALL let the highest-index port win same-cycle same-address writes, and SHALL set err_wr_conflict on the following edge.
REQ-022 SHALL ignore out-of-range writes (memory unchanged) and SHALL set err_oob.
REQ-023 SHALL sample rd_en[i]/rd_addr[i] on edge N and present dout[i] and dout_valid[i]=1 exactly after edge N+RD_LATENCY-1 (RD_LATENCY=1: valid the cycle after the request).
REQ-024 SHALL pipeline each read port independently; back-to-back requests every cycle SHALL yield valid every cycle, in order.
REQ-025 SHALL drive dout_valid[i]=0 in a cycle with no matching request, and SHALL hold the last dout[i] value when valid is low.
REQ-026 SHALL return all-zero data with valid=1 for an out-of-range read, and SHALL set err_oob.
REQ-027 With RDW_MODE=READ_OLD, a read of an address written on the same edge SHALL return the pre-write value.
REQ-028 With RDW_MODE=WRITE_FIRST, a same-edge read SHALL return the winning write data (per REQ-021).
REQ-029 SHALL increment err_count once per cycle with any conflict or OOB event, saturating at 16'hFFFF.
REQ-030 SHALL keep error flags set until rst.

Reset
REQ-031 While rst=1 SHALL drive dout_valid=0, dout=0, err_wr_conflict=0, err_oob=0, err_count=0, and SHALL flush all read pipeline stages.
REQ-032 SHALL ignore rd_en and wr_en while rst=1; memory contents SHALL be retained across reset (no reset on the array).
REQ-033 A read in flight when rst asserts SHALL never produce dout_valid=1.

Structure
REQ-034 The shared package memref_pkg SHALL hold the rdw_mode_e enum (READ_OLD, WRITE_FIRST) and the ERR_CNT_W=16 constant.
REQ-035 Per-port latency SHALL be implemented in one sub-module, memref_rd_pipe (valid+data shift of depth RD_LATENCY, with synchronous clear), instantiated NUM_RD times.

Verification
REQ-036 Defaults; write 32'hA5A5_0001 to addr 3, read addr 3 on the next cycle -> dout[0]=32'hA5A5_0001 with valid one cycle after the request.
REQ-037 RD_LATENCY=3, NUM_RD=2; port0 reads addr 0,1,2 on consecutive cycles, port1 idle -> three consecutive valids on port0 starting 3 cycles after the first request; dout_valid[1]=0 throughout.
REQ-038 NUM_WR=2; both ports write addr 5 (port0 32'h1, port1 32'h2) -> mem[5]=32'h2, err_wr_conflict=1, err_count=1.
REQ-039 Addr 5 holds 32'h7; same-edge write 32'h9 to addr 5 and read addr 5 -> dout=32'h7 with READ_OLD, 32'h9 with WRITE_FIRST.
REQ-040 SIZE=6; read addr 7 -> valid with dout=0, err_oob=1; write addr 6 -> no memory change.
REQ-041 RD_LATENCY=2; issue a read, assert rst for one cycle on the next edge -> no dout_valid, flags cleared, previously written data still readable after reset.

Source files
------------

// File: rtl/memref_pkg.sv
// Shared types and constants for the multiport memory reference block.
package memref_pkg;

    typedef enum logic [0:0] {
        READ_OLD    = 1'b0,
        WRITE_FIRST = 1'b1
    } rdw_mode_e;

    localparam int ERR_CNT_W = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

endpackage

// File: rtl/memref_rd_pipe.sv
// Fixed-latency read return pipeline for one read port.
// Data in each stage only advances with a valid beat, so the output holds the last returned word.
module memref_rd_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [LATENCY-1:0]            valid_q;
    logic [LATENCY-1:0]            valid_d;
    logic [LATENCY-1:0][WIDTH-1:0] data_q;
    logic [LATENCY-1:0][WIDTH-1:0] data_d;

    // Shift valid every cycle; move data only alongside a valid beat.
    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        valid_d[0] = valid_i;
        if (valid_i) begin
            data_d[0] = data_i;
        end else begin
            data_d[0] = data_q[0];
        end
        for (int k = 1; k < LATENCY; k++) begin
            valid_d[k] = valid_q[k-1];
            if (valid_q[k-1]) begin
                data_d[k] = data_q[k-1];
            end else begin
                data_d[k] = data_q[k];
            end
        end
    end

    // Stage registers with synchronous flush.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/memref_multiport.sv
// Multi-read / multi-write register-file memory with configurable read latency,
// read-during-write policy and sticky error reporting.
module memref_multiport
    import memref_pkg::*;
#(
    parameter int        WIDTH      = 32,
    parameter int        SIZE       = 8,
    parameter int        NUM_RD     = 2,
    parameter int        NUM_WR     = 1,
    parameter int        RD_LATENCY = 1,
    parameter rdw_mode_e RDW_MODE   = READ_OLD,
    localparam int       AW         = $clog2(SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_RD-1:0]       rd_en,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD-1:0]       dout_valid,
    output logic [NUM_RD*WIDTH-1:0] dout,
    input  logic [NUM_WR-1:0]       wr_en,
    input  logic [NUM_WR*AW-1:0]    wr_addr,
    input  logic [NUM_WR*WIDTH-1:0] din,
    output logic                    err_wr_conflict,
    output logic                    err_oob,
    output logic [ERR_CNT_W-1:0]    err_count
);

    localparam logic [AW:0] SIZE_W = (AW+1)'(SIZE);

    // SIZE need not be a power of two, so compare with one spare bit.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < SIZE_W);
    endfunction

    logic [WIDTH-1:0]              mem_q [SIZE];
    logic [NUM_WR-1:0]             wr_ok_s;
    logic [NUM_RD-1:0]             rd_req_s;
    logic [NUM_RD-1:0][WIDTH-1:0]  rd_data_s;
    logic                          conflict_s;
    logic                          oob_s;
    logic                          err_conflict_q;
    logic                          err_conflict_d;
    logic                          err_oob_q;
    logic                          err_oob_d;
    logic [ERR_CNT_W-1:0]          err_count_q;
    logic [ERR_CNT_W-1:0]          err_count_d;

    // Qualify requests (reset masks everything) and classify this cycle's error events.
    always_comb begin
        wr_ok_s    = '0;
        rd_req_s   = '0;
        conflict_s = 1'b0;
        oob_s      = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            wr_ok_s[j] = wr_en[j] & ~rst & addr_ok(wr_addr[j*AW +: AW]);
            oob_s      = oob_s | (wr_en[j] & ~rst & ~addr_ok(wr_addr[j*AW +: AW]));
        end
        for (int i = 0; i < NUM_RD; i++) begin
            rd_req_s[i] = rd_en[i] & ~rst;
            oob_s       = oob_s | (rd_req_s[i] & ~addr_ok(rd_addr[i*AW +: AW]));
        end
        for (int j = 0; j < NUM_WR; j++) begin
            for (int k = j + 1; k < NUM_WR; k++) begin
                conflict_s = conflict_s | (wr_ok_s[j] & wr_ok_s[k] &
                             (wr_addr[j*AW +: AW] == wr_addr[k*AW +: AW]));
            end
        end
    end

    // Read word at the sampling edge; later write ports override earlier ones when forwarding.
    always_comb begin
        rd_data_s = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data_s[i] = addr_ok(rd_addr[i*AW +: AW]) ? mem_q[rd_addr[i*AW +: AW]] : '0;
            for (int j = 0; j < NUM_WR; j++) begin
                if ((RDW_MODE == WRITE_FIRST) && wr_ok_s[j] &&
                    (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
                    rd_data_s[i] = din[j*WIDTH +: WIDTH];
                end else begin
                    rd_data_s[i] = rd_data_s[i];
                end
            end
        end
    end

    // Sticky flags and saturating error-cycle counter.
    always_comb begin
        err_conflict_d = err_conflict_q | conflict_s;
        err_oob_d      = err_oob_q | oob_s;
        if ((conflict_s || oob_s) && (err_count_q != ERR_CNT_MAX)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Error state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_conflict_q <= 1'b0;
            err_oob_q      <= 1'b0;
            err_count_q    <= '0;
        end else begin
            err_conflict_q <= err_conflict_d;
            err_oob_q      <= err_oob_d;
            err_count_q    <= err_count_d;
        end
    end

    // Storage is deliberately not reset; the highest-index port's write lands last.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_ok_s[j]) begin
                mem_q[wr_addr[j*AW +: AW]] <= din[j*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        memref_rd_pipe #(
            .WIDTH   (WIDTH),
            .LATENCY (RD_LATENCY)
        ) u_pipe (
            .clk     (clk),
            .clr_i   (rst),
            .valid_i (rd_req_s[i]),
            .data_i  (rd_data_s[i]),
            .valid_o (dout_valid[i]),
            .data_o  (dout[i*WIDTH +: WIDTH])
        );
    end

    assign err_wr_conflict = err_conflict_q;
    assign err_oob         = err_oob_q;
    assign err_count       = err_count_q;

endmodule

// File: tb/tb_memref_multiport.sv
// Scoreboard bench: two instances (READ_OLD/lat 1 and WRITE_FIRST/lat 3) share one stimulus stream
// and are compared against an array-based reference memory.
module tb_memref_multiport;
    import memref_pkg::*;

    localparam int SZ    = 6;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  rd_en = 2'b00;
    logic [5:0]  rd_addr = 6'd0;
    logic [1:0]  wr_en = 2'b00;
    logic [5:0]  wr_addr = 6'd0;
    logic [63:0] din = 64'd0;

    logic [1:0]  dv   [2];
    logic [63:0] dq   [2];
    logic        ec   [2];
    logic        eo   [2];
    logic [15:0] cntv [2];

    int          cmp = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          mon_on = 1'b0;
    exp_t        q [4][$];
    logic [31:0] last [4];
    logic [31:0] mem_m [SZ];
    logic        exp_conf = 1'b0;
    logic        exp_oob = 1'b0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memref_multiport #(
        .WIDTH(32), .SIZE(SZ), .NUM_RD(2), .NUM_WR(2), .RD_LATENCY(LAT_A), .RDW_MODE(READ_OLD)
    ) dut_a (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .dout_valid(dv[0]), .dout(dq[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .din(din),
        .err_wr_conflict(ec[0]), .err_oob(eo[0]), .err_count(cntv[0])
    );

    memref_multiport #(
        .WIDTH(32), .SIZE(SZ), .NUM_RD(2), .NUM_WR(2), .RD_LATENCY(LAT_B), .RDW_MODE(WRITE_FIRST)
    ) dut_b (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .dout_valid(dv[1]), .dout(dq[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .din(din),
        .err_wr_conflict(ec[1]), .err_oob(eo[1]), .err_count(cntv[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: predict the effect of the upcoming edge from the current inputs.
    task automatic model_edge();
        int          e;
        int          a;
        int          wa;
        logic [31:0] old_v;
        logic [31:0] new_v;
        logic        ev_c;
        logic        ev_o;
        exp_t        it;
        e    = cyc + 1;
        ev_c = 1'b0;
        ev_o = 1'b0;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                q[k].delete();
                last[k] = 32'd0;
            end
            exp_conf = 1'b0;
            exp_oob  = 1'b0;
            exp_cnt  = 16'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                a = int'(rd_addr[i*3 +: 3]);
                if (rd_en[i]) begin
                    old_v = (a < SZ) ? mem_m[a] : 32'd0;
                    new_v = old_v;
                    for (int j = 0; j < 2; j++) begin
                        if (a < SZ && wr_en[j] && int'(wr_addr[j*3 +: 3]) == a)
                            new_v = din[j*32 +: 32];
                    end
                    if (a >= SZ) ev_o = 1'b1;
                    it.data = old_v; it.due = e + LAT_A - 1; q[i].push_back(it);
                    it.data = new_v; it.due = e + LAT_B - 1; q[2+i].push_back(it);
                end
            end
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j] && int'(wr_addr[j*3 +: 3]) >= SZ) ev_o = 1'b1;
            end
            if (wr_en == 2'b11 && wr_addr[2:0] == wr_addr[5:3] && int'(wr_addr[2:0]) < SZ) ev_c = 1'b1;
            exp_conf = exp_conf | ev_c;
            exp_oob  = exp_oob | ev_o;
            if ((ev_c || ev_o) && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            for (int j = 0; j < 2; j++) begin
                wa = int'(wr_addr[j*3 +: 3]);
                if (wr_en[j] && wa < SZ) mem_m[wa] = din[j*32 +: 32];
            end
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] re, input logic [2:0] ra0, input logic [2:0] ra1,
                         input logic [1:0] we, input logic [2:0] wa0, input logic [2:0] wa1,
                         input logic [31:0] d0, input logic [31:0] d1);
        @(negedge clk);
        rst     = r;
        rd_en   = re;
        rd_addr = {ra1, ra0};
        wr_en   = we;
        wr_addr = {wa1, wa0};
        din     = {d1, d0};
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) drive(1'b0, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
    endtask

    // Monitor: pop the scoreboard whenever a read is due and compare outputs and flags.
    initial begin
        exp_t it;
        bit   ev;
        int   k;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                for (int d = 0; d < 2; d++) begin
                    for (int i = 0; i < 2; i++) begin
                        k  = d * 2 + i;
                        ev = (q[k].size() != 0) && (q[k][0].due <= cyc);
                        check($sformatf("rd_valid[d%0d p%0d]", d, i), 32'(dv[d][i]), 32'(ev));
                        if (ev) begin
                            it = q[k].pop_front();
                            if (dv[d][i]) begin
                                check($sformatf("rd_data[d%0d p%0d]", d, i), dq[d][i*32 +: 32], it.data);
                                check($sformatf("rd_latency[d%0d p%0d]", d, i), 32'(cyc), 32'(it.due));
                                last[k] = it.data;
                            end
                        end else if (!dv[d][i]) begin
                            check($sformatf("rd_hold[d%0d p%0d]", d, i), dq[d][i*32 +: 32], last[k]);
                        end
                    end
                    check($sformatf("err_wr_conflict[d%0d]", d), 32'(ec[d]), 32'(exp_conf));
                    check($sformatf("err_oob[d%0d]", d), 32'(eo[d]), 32'(exp_oob));
                    check($sformatf("err_count[d%0d]", d), 32'(cntv[d]), 32'(exp_cnt));
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 4; k++) last[k] = 32'd0;
        for (int a = 0; a < SZ; a++) mem_m[a] = 32'd0;
        drive(1'b1, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
        mon_on = 1'b1;
        drive(1'b1, 2'b11, 3'd1, 3'd2, 2'b11, 3'd0, 3'd1, 32'hBAD0, 32'hBAD1);
        // Initialise every word, including A5A5_0001 at address 3.
        drive(1'b0, 2'b00, 3'd0, 3'd0, 2'b11, 3'd0, 3'd1, 32'h100, 32'h101);
        drive(1'b0, 2'b00, 3'd0, 3'd0, 2'b11, 3'd2, 3'd3, 32'h102, 32'hA5A5_0001);
        drive(1'b0, 2'b00, 3'd0, 3'd0, 2'b11, 3'd4, 3'd5, 32'h104, 32'h105);
        drive(1'b0, 2'b01, 3'd3, 3'd0, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
        idle(3);
        // Back-to-back reads on port 0, port 1 idle.
        drive(1'b0, 2'b01, 3'd0, 3'd0, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
        drive(1'b0, 2'b01, 3'd1, 3'd0, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
        drive(1'b0, 2'b01, 3'd2, 3'd0, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
        idle(4);
        // Same-address write conflict, then read back the winner.
        drive(1'b0, 2'b00, 3'd0, 3'd0, 2'b11, 3'd5, 3'd5, 32'h1, 32'h2);
        drive(1'b0, 2'b10, 3'd0, 3'd5, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
        idle(4);
        // Read during write.
        drive(1'b0, 2'b00, 3'd0, 3'd0, 2'b01, 3'd5, 3'd0, 32'h7, 32'd0);
        drive(1'b0, 2'b01, 3'd5, 3'd0, 2'b01, 3'd5, 3'd0, 32'h9, 32'd0);
        idle(4);
        // Out-of-range read and write.
        drive(1'b0, 2'b10, 3'd0, 3'd7, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
        drive(1'b0, 2'b00, 3'd0, 3'd0, 2'b01, 3'd6, 3'd0, 32'hDEAD, 32'd0);
        drive(1'b0, 2'b11, 3'd5, 3'd4, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
        idle(4);
        // Reset with a read in flight; contents survive reset.
        drive(1'b0, 2'b01, 3'd2, 3'd0, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 2'b11, 3'd0, 3'd1, 2'b11, 3'd0, 3'd1, 32'hEEE0, 32'hEEE1);
        drive(1'b0, 2'b11, 3'd2, 3'd3, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
        idle(4);
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 39) == 0), 2'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  2'($urandom), 3'($urandom_range(0, 6)), 3'($urandom_range(0, 6)),
                  $urandom, $urandom);
        end
        idle(LAT_B + 2);
        for (int k = 0; k < 4; k++) check($sformatf("drain[%0d]", k), 32'(q[k].size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
